// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared types and constant helpers for the serial receive front end.
//   state_t         : receiver sampler FSM states (ST_IDLE, ST_START, ST_RUN)
//   clog2()         : ceiling log2, usable in parameter expressions
//   mid_count()     : phase count at the nominal bit centre
//   win_lo/win_hi() : first and last phase counts of the majority-vote window
// ---------------------------------------------------------------------------
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int mid_count(input int oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int win_lo(input int oversample, input int vote_n);
    return mid_count(oversample) - vote_n / 2;
  endfunction

  function automatic int win_hi(input int oversample, input int vote_n);
    return mid_count(oversample) + vote_n / 2;
  endfunction

endpackage

// File: rtl/serial_rx_sync.sv
// ---------------------------------------------------------------------------
// serial_rx_sync
// Brings the asynchronous RXD pin into the module clock domain and flags
// 1-to-0 transitions of the synchronised line. All flops reset to the
// line-idle level (1) so releasing reset never fabricates an edge.
// Ports:
//   i_clk    : module clock
//   i_rst_b  : synchronous active-low reset
//   i_rxd    : asynchronous RXD pin
//   o_rx_s   : synchronised RXD (last synchroniser stage)
//   o_fall   : combinational 1-to-0 edge of o_rx_s (o_rx_s delayed & ~o_rx_s)
// ---------------------------------------------------------------------------
module serial_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_b,
  input  logic i_rxd,
  output logic o_rx_s,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_rx_d;

  // NOTE: non-blocking assignments make every stage capture the value its
  // predecessor held before the edge, which is what builds a shift chain.
  always_ff @(posedge i_clk) begin
    if (!i_rst_b) begin
      r_sync <= '1;
      r_rx_d <= 1'b1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
      r_rx_d <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rx_s = r_sync[SYNC_STAGES-1];
  assign o_fall = r_rx_d & ~o_rx_s;

endmodule

// File: rtl/serial_rx_sampler.sv
// ---------------------------------------------------------------------------
// serial_rx_sampler
// Receive front end: synchronises RXD, detects falling edges, validates the
// start bit and majority-votes each bit around mid-period using the
// oversampling tick. Single clock domain; the baud tick is an enable.
// Optional feature macro: SERIAL_RX_RESYNC_EN -- in RUN, a falling edge seen
// after the vote window reloads the phase counter to absorb baud drift.
// Ports:
//   serial_clock_i / serial_reset_i_b : clock, synchronous active-low reset
//   serial_baud_tick_i                : one-cycle enable at OVERSAMPLE x baud
//   serial_rxd_data_i                 : asynchronous RXD pin
//   serial_enable_i                   : receiver enable (0 forces IDLE)
//   serial_clear_count_i              : abort/resync request (forces IDLE)
//   serial_transition_detected_o      : pulse, synchronised 1-to-0 edge
//   serial_start_valid_o              : pulse, start bit confirmed
//   serial_false_start_o              : pulse, start bit rejected
//   serial_shift_o                    : pulse, serial_sample_detected_o updated
//   serial_sample_detected_o          : voted bit value
//   serial_noise_o                    : pulse, vote was not unanimous
//   serial_count_o                    : phase counter
// ---------------------------------------------------------------------------
module serial_rx_sampler
  import serial_pkg::*;
#(
  parameter  int OVERSAMPLE  = 16,
  parameter  int VOTE_N      = 3,
  parameter  int SYNC_STAGES = 2,
  localparam int CNT_W       = clog2(OVERSAMPLE)
) (
  input  logic             serial_clock_i,
  input  logic             serial_reset_i_b,
  input  logic             serial_baud_tick_i,
  input  logic             serial_rxd_data_i,
  input  logic             serial_enable_i,
  input  logic             serial_clear_count_i,
  output logic             serial_transition_detected_o,
  output logic             serial_start_valid_o,
  output logic             serial_false_start_o,
  output logic             serial_shift_o,
  output logic             serial_sample_detected_o,
  output logic             serial_noise_o,
  output logic [CNT_W-1:0] serial_count_o
);

  localparam int ONES_W = clog2(VOTE_N + 1);
  localparam logic [CNT_W-1:0]  C_LO   = CNT_W'(win_lo(OVERSAMPLE, VOTE_N));
  localparam logic [CNT_W-1:0]  C_HI   = CNT_W'(win_hi(OVERSAMPLE, VOTE_N));
  localparam logic [CNT_W-1:0]  C_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [ONES_W-1:0] O_HALF = ONES_W'(VOTE_N / 2);
  localparam logic [ONES_W-1:0] O_ALL  = ONES_W'(VOTE_N);

  logic w_rx_s;
  logic w_fall;

  serial_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (serial_clock_i),
    .i_rst_b (serial_reset_i_b),
    .i_rxd   (serial_rxd_data_i),
    .o_rx_s  (w_rx_s),
    .o_fall  (w_fall)
  );

  state_t            r_state;
  logic [CNT_W-1:0]  r_count;
  logic [ONES_W-1:0] r_ones;
  logic              r_trans;
  logic              r_start_valid;
  logic              r_false_start;
  logic              r_shift;
  logic              r_sample;
  logic              r_noise;

  // The deciding tick folds the current sample in before comparing, so the
  // vote covers all VOTE_N window ticks without an extra cycle.
  logic [ONES_W-1:0] w_ones_total;
  logic              w_in_window;
  logic              w_vote;
  logic              w_noisy;
  logic [CNT_W-1:0]  w_count_next;
  logic              w_resync;

  assign w_ones_total = r_ones + ONES_W'(w_rx_s);
  assign w_in_window  = (r_count >= C_LO) && (r_count <= C_HI);
  assign w_vote       = w_ones_total > O_HALF;
  assign w_noisy      = (w_ones_total != '0) && (w_ones_total != O_ALL);
  assign w_count_next = (r_count == C_LAST) ? '0 : r_count + CNT_W'(1);

`ifdef SERIAL_RX_RESYNC_EN
  // An edge after the vote window is taken as the true bit boundary.
  assign w_resync = (r_state == ST_RUN) && w_fall && (r_count > C_HI);
`else
  assign w_resync = 1'b0;
`endif

  // NOTE: reset is sampled on the clock edge, so it sits inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge serial_clock_i) begin
    if (!serial_reset_i_b) begin
      r_state       <= ST_IDLE;
      r_count       <= '0;
      r_ones        <= '0;
      r_trans       <= 1'b0;
      r_start_valid <= 1'b0;
      r_false_start <= 1'b0;
      r_shift       <= 1'b0;
      r_sample      <= 1'b1;
      r_noise       <= 1'b0;
    end else begin
      r_trans       <= w_fall;
      r_start_valid <= 1'b0;
      r_false_start <= 1'b0;
      r_shift       <= 1'b0;
      r_noise       <= 1'b0;

      if (!serial_enable_i || serial_clear_count_i) begin
        // Abort: any coincident edge is dropped; the voted bit is retained.
        r_state <= ST_IDLE;
        r_count <= '0;
        r_ones  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_count <= '0;
            r_ones  <= '0;
            if (w_fall) r_state <= ST_START;
          end

          ST_START, ST_RUN: begin
            if (w_resync) begin
              r_count <= '0;
              r_ones  <= '0;
            end else if (serial_baud_tick_i) begin
              r_count <= w_count_next;
              if (w_in_window) begin
                if (r_count == C_HI) begin
                  r_ones  <= '0;
                  r_noise <= w_noisy;
                  if (r_state == ST_START) begin
                    if (w_vote) begin
                      r_false_start <= 1'b1;
                      r_state       <= ST_IDLE;
                      r_count       <= '0;
                    end else begin
                      r_start_valid <= 1'b1;
                      r_state       <= ST_RUN;
                    end
                  end else begin
                    r_shift  <= 1'b1;
                    r_sample <= w_vote;
                  end
                end else begin
                  r_ones <= w_ones_total;
                end
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_ones  <= '0;
          end
        endcase
      end
    end
  end

  assign serial_transition_detected_o = r_trans;
  assign serial_start_valid_o         = r_start_valid;
  assign serial_false_start_o         = r_false_start;
  assign serial_shift_o               = r_shift;
  assign serial_sample_detected_o     = r_sample;
  assign serial_noise_o               = r_noise;
  assign serial_count_o               = r_count;

endmodule

// File: tb/tb_serial_rx_sampler.sv
// ---------------------------------------------------------------------------
// tb_serial_rx_sampler
// Directed bench for serial_rx_sampler at default parameters, baud tick every
// fourth clock. Frames start right after a ticking clock edge (t0), so every
// expected event lands on a fixed clock offset from t0:
//   edge seen / START entered at t0+3, tick at count c on t0+4*(c+1),
//   start decision at t0+36, data bit k decision at t0+36+64*(k+1),
//   sample at posedge P reflects RXD as it stood at posedge P-2.
// ---------------------------------------------------------------------------
module tb_serial_rx_sampler;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       tick;
  logic       rxd;
  logic       enable;
  logic       clear;
  logic       trans_o;
  logic       start_o;
  logic       false_o;
  logic       shift_o;
  logic       sample_o;
  logic       noise_o;
  logic [3:0] count_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int t0     = 0;
  int n_trans, n_start, n_false, n_shift, n_noise;

  serial_rx_sampler dut (
    .serial_clock_i               (clk),
    .serial_reset_i_b             (rst_b),
    .serial_baud_tick_i           (tick),
    .serial_rxd_data_i            (rxd),
    .serial_enable_i              (enable),
    .serial_clear_count_i         (clear),
    .serial_transition_detected_o (trans_o),
    .serial_start_valid_o         (start_o),
    .serial_false_start_o         (false_o),
    .serial_shift_o               (shift_o),
    .serial_sample_detected_o     (sample_o),
    .serial_noise_o               (noise_o),
    .serial_count_o               (count_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: outputs are read 1 time unit after the edge; the tick is
  // raised so that it is seen by every posedge whose index is a multiple of 4.
  task automatic clk1();
    @(posedge clk);
    #1;
    cyc++;
    tick = ((cyc % 4) == 3);
    if (trans_o) n_trans++;
    if (start_o) n_start++;
    if (false_o) n_false++;
    if (shift_o) n_shift++;
    if (noise_o) n_noise++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  task automatic go_to(input int rel);
    while (cyc < t0 + rel) clk1();
  endtask

  task automatic clear_mon();
    n_trans = 0; n_start = 0; n_false = 0; n_shift = 0; n_noise = 0;
  endtask

  // Align to a ticking edge and drive the start bit.
  task automatic begin_frame();
    while ((cyc % 4) != 0) clk1();
    clear_mon();
    t0  = cyc;
    rxd = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    clk1();
    clear = 1'b0;
  endtask

  logic [7:0] frame_byte;

  initial begin
    rst_b  = 1'b0;
    tick   = 1'b0;
    rxd    = 1'b0;
    enable = 1'b1;
    clear  = 1'b0;
    clear_mon();

    // ---------------- reset ----------------
    run(6);
    check("rst_sample", sample_o, 1);
    check("rst_count",  count_o,  0);
    check("rst_trans",  trans_o,  0);
    check("rst_start",  start_o,  0);
    check("rst_false",  false_o,  0);
    check("rst_shift_noise", {shift_o, noise_o}, 0);
    rxd   = 1'b1;
    rst_b = 1'b1;
    clear_mon();
    run(20);
    check("idle_pulses", n_trans + n_start + n_false + n_shift + n_noise, 0);
    check("idle_count",  count_o, 0);

    // ---------------- clean frame 0x55 ----------------
    frame_byte = 8'h55;
    begin_frame();
    go_to(3);
    check("frm_trans",  trans_o, 1);
    check("frm_cnt0",   count_o, 0);
    go_to(4);
    check("frm_cnt1",   count_o, 1);
    go_to(36);
    check("frm_start",  start_o, 1);
    check("frm_trans1", n_trans, 1);
    for (int k = 0; k < 8; k++) begin
      go_to(64 * (k + 1));
      rxd = frame_byte[k];
      go_to(36 + 64 * (k + 1));
      check($sformatf("frm_shift%0d", k),  shift_o,  1);
      check($sformatf("frm_sample%0d", k), sample_o, frame_byte[k]);
    end
    go_to(576);
    rxd = 1'b1;
    go_to(580);
    pulse_clear();
    check("frm_clr_cnt",  count_o, 0);
    run(3);
    check("frm_hold",     sample_o, 0);
    check("frm_n_start",  n_start, 1);
    check("frm_n_shift",  n_shift, 8);
    check("frm_n_noise",  n_noise, 0);
    check("frm_n_false",  n_false, 0);
    check("frm_n_trans",  n_trans, 5);
    run(40);
    check("frm_no_run",   n_shift, 8);

    // ---------------- glitch start ----------------
    begin_frame();
    go_to(12);
    rxd = 1'b1;
    go_to(36);
    check("gl_false",  false_o, 1);
    check("gl_start",  start_o, 0);
    check("gl_noise",  noise_o, 0);
    go_to(40);
    check("gl_idle_cnt", count_o, 0);
    go_to(120);
    check("gl_no_shift", n_shift, 0);
    check("gl_n_trans",  n_trans, 1);

    // ---------------- noisy '1' bit ----------------
    begin_frame();
    go_to(36);
    check("nz_start", start_o, 1);
    go_to(64);
    rxd = 1'b1;
    go_to(93);
    rxd = 1'b0;
    go_to(94);
    rxd = 1'b1;
    go_to(100);
    check("nz_shift",  shift_o,  1);
    check("nz_sample", sample_o, 1);
    check("nz_noise",  noise_o,  1);
    go_to(104);
    pulse_clear();
    run(20);

    // ---------------- clear mid-bit ----------------
    begin_frame();
    go_to(64);
    rxd = 1'b1;
    go_to(87);
    clear = 1'b1;
    go_to(88);
    clear = 1'b0;
    check("clr_cnt", count_o, 0);
    go_to(110);
    check("clr_no_shift", n_shift, 0);
    go_to(120);
    rxd = 1'b0;
    go_to(123);
    check("clr_re_trans", trans_o, 1);
    check("clr_re_cnt0",  count_o, 0);
    go_to(124);
    check("clr_re_cnt1",  count_o, 1);
    go_to(156);
    check("clr_re_start", start_o, 1);
    rxd = 1'b1;
    run(4);
    pulse_clear();
    run(20);

    // ---------------- resync at count 14 ----------------
    begin_frame();
    go_to(64);
    rxd = 1'b1;
    go_to(119);
    rxd = 1'b0;
    go_to(122);
`ifdef SERIAL_RX_RESYNC_EN
    check("rs_reload", count_o, 0);
    go_to(124);
    check("rs_next",   count_o, 1);
`else
    check("rs_hold",   count_o, 14);
    go_to(124);
    check("rs_next",   count_o, 15);
`endif
    rxd = 1'b1;
    pulse_clear();
    run(8);
    check("rs_end_cnt", count_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
